mpu_matrix_loader: RTL and testbench
====================================

Name: mpu_matrix_loader

Overview:
- Upstream stage of the MPU determinant unit. Collects a serial byte stream into one packed 5x5 8-bit matrix and presents it, with its size, as a single stable word.
- Uses a valid/ready handshake on both sides, so the combinational determinant stage only ever sees a complete, zero-padded matrix.

Parameters:
- DIM, 5, maximum matrix dimension. Packing is defined for 5; only the default is supported and verified.
- ELEM_W, 8, element width in bits.

Ports:
- clk  input  1  system clock; everything rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  load command, sampled only in IDLE.
- start_size  input  8  matrix dimension for this load; legal values 1..5.
- in_data  input  8  stream element.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data.
- out_matrix  output  200  packed matrix, ascending vector [0:199].
- out_size  output  8  dimension of out_matrix.
- out_valid  output  1  out_matrix and out_size are complete.
- out_ready  input  1  downstream consumes the matrix.
- busy  output  1  high when state is not IDLE.
- err  output  1  one-cycle pulse on an illegal start_size.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; out_matrix = 0, out_size = 0, out_valid = 0, in_ready = 0, busy = 0, err = 0; row and column counters = 0.
- Reset mid-load or mid-present discards all contents. No partial output is ever flagged valid.
- Packing: element (i,j) is the 8-bit slice at offset 8*(j+5*i), i.e. out_matrix[8*(j+5*i) +: 8]. i is the first index (stream row), j is the second.
- All outputs are registered. States: IDLE, LOAD, PRESENT.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start high and start_size in 1..5: latch out_size; clear out_matrix to 0; i = j = 0; go to LOAD.
  - start high and start_size = 0 or > 5: err = 1 for exactly the next cycle; stay in IDLE; out_matrix and out_size unchanged.
- LOAD:
  - in_ready = 1 from the first cycle in LOAD.
  - A beat is accepted when in_valid & in_ready. The beat is written to element (i,j), then j increments. When j = size-1, j wraps to 0 and i increments.
  - Cycles with in_valid low stall; counters hold.
  - When the beat at (size-1, size-1) is accepted: go to PRESENT. Next cycle in_ready = 0 and out_valid = 1, so latency is 1 cycle after the last accepted beat.
  - Elements outside the size x size window remain 0.
- PRESENT:
  - out_valid = 1; out_matrix and out_size held stable while out_ready is low.
  - out_valid & out_ready: go to IDLE; out_valid = 0 next cycle.
  - out_matrix and out_size keep their values until the next legal start.
- start is ignored in LOAD and PRESENT, including in the handshake cycle. It is never queued.
- in_data is ignored whenever in_ready = 0.
- Size 1: a single beat; PRESENT follows one cycle later.
- Counters are 3 bits wide and never exceed 4.

Optional Feature:
- Macro: MPU_LOADER_TRANSPOSE_EN.
- Defined: the stream is column-major. The k-th beat (counters i outer, j inner) is stored at element (j,i), offset 8*(i+5*j). All handshake and timing behaviour is identical.
- Undefined: row-major storage as described above.

Test Plan:
- start, size 2; beats 1,2,3,4 back-to-back -> out_valid rises 1 cycle after the 4th beat. Expected (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4, other 21 elements 0, out_size = 2. With TRANSPOSE_EN: (0,1)=3 and (1,0)=2.
- start with size 0, then with size 6 -> err high for exactly one cycle each; busy and in_ready stay 0; out_size unchanged.
- size 5; beats 1..25 with in_valid low every other cycle; out_ready held low 10 cycles -> element (i,j) = 5i+j+1 and stays stable throughout. out_ready high -> out_valid and busy both low on the next cycle.
- Load 4x4 of 0xFF, consume it, then load 3x3 of 1..9 -> row 3, column 3 and row/column 4 all read 0; out_size = 3.
- size 3 load; rst_n low after 3 beats -> all outputs at reset values. Then start size 1 with beat 7 -> (0,0) = 7, out_valid after 1 cycle.
- start with size 4 pulsed during a size-2 LOAD and again in the PRESENT handshake cycle -> both ignored; out_size = 2; loader returns to IDLE.

Source files
------------

// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader: collects a serial element stream into one packed
// DIM x DIM matrix, zero-padded outside the loaded size x size window, and
// presents it with its size over a valid/ready handshake.
// Optional build macro: MPU_LOADER_TRANSPOSE_EN (stream treated as
// column-major: beat for counters (i,j) is stored at element (j,i)).
// Only DIM = 5, ELEM_W = 8 is supported.
module mpu_matrix_loader #(
  parameter int unsigned DIM    = 5,
  parameter int unsigned ELEM_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   start_size,
  input  logic [ELEM_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [0:DIM*DIM*ELEM_W-1]    out_matrix,
  output logic [7:0]                   out_size,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned MAT_W = DIM * DIM * ELEM_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PRESENT
  } state_t;

  state_t             state_q;
  logic [0:MAT_W-1]   mat_q;
  logic [7:0]         size_q;
  logic [2:0]         i_q;
  logic [2:0]         j_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               err_q;

  logic [4:0]         elem_idx;
  logic [7:0]         bit_off;
  logic               last_col;
  logic               last_row;
  logic               size_ok;
  logic               accept;

  // Element slot addressed by the current counters, plus handshake decodes.
  always_comb begin
`ifdef MPU_LOADER_TRANSPOSE_EN
    elem_idx = 5'(j_q) * 5'(DIM) + 5'(i_q);
`else
    elem_idx = 5'(i_q) * 5'(DIM) + 5'(j_q);
`endif
    bit_off  = 8'(32'(elem_idx) * ELEM_W);
    last_col = ((j_q + 3'd1) == size_q[2:0]);
    last_row = ((i_q + 3'd1) == size_q[2:0]);
    size_ok  = (start_size != 8'd0) && (start_size <= 8'(DIM));
    accept   = in_valid & in_ready_q;
  end

  // Loader FSM with all outputs held in registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mat_q       <= '0;
      size_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (size_ok) begin
              size_q     <= start_size;
              mat_q      <= '0;
              i_q        <= '0;
              j_q        <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            mat_q[bit_off +: ELEM_W] <= in_data;
            if (last_col) begin
              j_q <= '0;
              if (last_row) begin
                i_q         <= '0;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= PRESENT;
              end else begin
                i_q <= i_q + 3'd1;
              end
            end else begin
              j_q <= j_q + 3'd1;
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_matrix = mat_q;
  assign out_size   = size_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Bench for mpu_matrix_loader: directed loads; expected matrices are queued
// when stimulus is issued and a negedge monitor compares them against the
// presented output every cycle out_valid is high, popping on handshake.
module tb_mpu_matrix_loader;

  typedef struct {
    logic [0:199] m;
    logic [7:0]   sz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   start_size;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [0:199] out_matrix;
  logic [7:0]   out_size;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         err;

  int           total = 0;
  int           bad   = 0;
  exp_t         exp_q[$];
  logic [0:199] last_m;

  mpu_matrix_loader #(.DIM(5), .ELEM_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_size (start_size),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_matrix (out_matrix),
    .out_size   (out_size),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkm(input string name, input logic [0:199] act, input logic [0:199] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: presented word must match the queue head while valid.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got out_valid=1 expected no pending matrix");
      end else begin
        chkm("mon_matrix", out_matrix, exp_q[0].m);
        chk("mon_size", int'(out_size), int'(exp_q[0].sz));
        if (out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] sz);
    start = 1'b1;
    start_size = sz;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    chk("in_ready_beat", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data = v;
    tick();
    in_valid = 1'b0;
    in_data = 8'hA5;
  endtask

  function automatic logic [0:199] put(input logic [0:199] m, input int i, input int j,
                                       input logic [7:0] v);
    logic [0:199] r;
    r = m;
`ifdef MPU_LOADER_TRANSPOSE_EN
    r[8*(i+5*j) +: 8] = v;
`else
    r[8*(j+5*i) +: 8] = v;
`endif
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    chkm({tag, "_matrix"}, out_matrix, '0);
    chk({tag, "_size"}, int'(out_size), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // Full load: value k+1 for the k-th beat, or all 0xFF; optional stall cycles.
  task automatic load(input int sz, input bit ff, input bit stall);
    exp_t e;
    logic [7:0] v;
    e.m = '0;
    e.sz = 8'(sz);
    do_start(8'(sz));
    chk("load_busy", int'(busy), 1);
    chk("load_in_ready", int'(in_ready), 1);
    chk("load_no_valid", int'(out_valid), 0);
    for (int i = 0; i < sz; i++) begin
      for (int j = 0; j < sz; j++) begin
        v = ff ? 8'hFF : 8'(i*sz + j + 1);
        e.m = put(e.m, i, j, v);
        if (stall) begin
          in_data = 8'h5A;
          tick();
        end
        if (i == sz-1 && j == sz-1) begin
          exp_q.push_back(e);
          last_m = e.m;
        end
        send(v);
      end
    end
    chk("latency_valid", int'(out_valid), 1);
    chk("latency_in_ready", int'(in_ready), 0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_valid", int'(out_valid), 0);
    chk("consume_busy", int'(busy), 0);
  endtask

  task automatic bad_start(input logic [7:0] sz, input int exp_size);
    do_start(sz);
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    chk("err_in_ready", int'(in_ready), 0);
    chk("err_size_kept", int'(out_size), exp_size);
    chkm("err_matrix_kept", out_matrix, last_m);
    tick();
    chk("err_one_cycle", int'(err), 0);
  endtask

  initial begin
    logic [7:0] el;
    rst_n = 1'b0;
    start = 1'b0;
    start_size = 8'd0;
    in_data = 8'd0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    last_m = '0;
    tick();
    tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    // size 2, back-to-back beats, with hand-computed element checks
    load(2, 1'b0, 1'b0);
    el = out_matrix[0:7];    chk("s2_e00", int'(el), 1);
`ifdef MPU_LOADER_TRANSPOSE_EN
    el = out_matrix[8:15];   chk("s2_e01", int'(el), 3);
    el = out_matrix[40:47];  chk("s2_e10", int'(el), 2);
`else
    el = out_matrix[8:15];   chk("s2_e01", int'(el), 2);
    el = out_matrix[40:47];  chk("s2_e10", int'(el), 3);
`endif
    el = out_matrix[48:55];  chk("s2_e11", int'(el), 4);
    chk("s2_size", int'(out_size), 2);
    consume();

    // illegal sizes
    bad_start(8'd0, 2);
    bad_start(8'd6, 2);

    // size 5 with stalls, downstream backpressure for 10 cycles
    load(5, 1'b0, 1'b1);
    el = out_matrix[8*(3+5*2) +: 8];  chk("s5_e23", int'(el), 14);
    el = out_matrix[192:199];         chk("s5_e44", int'(el), 25);
    repeat (10) tick();
    chk("s5_held_valid", int'(out_valid), 1);
    consume();

    // 4x4 of 0xFF then 3x3: padding must be cleared
    load(4, 1'b1, 1'b0);
    consume();
    load(3, 1'b0, 1'b0);
    el = out_matrix[8*(3+5*3) +: 8];  chk("pad_e33", int'(el), 0);
    el = out_matrix[8*(0+5*3) +: 8];  chk("pad_e30", int'(el), 0);
    el = out_matrix[8*(3+5*0) +: 8];  chk("pad_e03", int'(el), 0);
    el = out_matrix[8*(2+5*2) +: 8];  chk("pad_e22", int'(el), 9);
    chk("pad_size", int'(out_size), 3);
    consume();

    // reset mid-load
    do_start(8'd3);
    send(8'd11);
    send(8'd12);
    send(8'd13);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("midreset");
    last_m = '0;
    load(1, 1'b0, 1'b0);
    el = out_matrix[0:7];  chk("s1_e00", int'(el), 1);
    consume();
    begin
      exp_t e;
      e.m = put('0, 0, 0, 8'd7);
      e.sz = 8'd1;
      do_start(8'd1);
      exp_q.push_back(e);
      send(8'd7);
      chk("s1b_latency", int'(out_valid), 1);
      el = out_matrix[0:7];  chk("s1b_e00", int'(el), 7);
      consume();
      last_m = e.m;
    end

    // start ignored during LOAD and in the PRESENT handshake cycle
    begin
      exp_t e;
      e.m = '0;
      e.m = put(e.m, 0, 0, 8'd5);
      e.m = put(e.m, 0, 1, 8'd6);
      e.m = put(e.m, 1, 0, 8'd7);
      e.m = put(e.m, 1, 1, 8'd8);
      e.sz = 8'd2;
      do_start(8'd2);
      start = 1'b1;
      start_size = 8'd4;
      send(8'd5);
      start = 1'b0;
      send(8'd6);
      send(8'd7);
      exp_q.push_back(e);
      send(8'd8);
      chk("ign_valid", int'(out_valid), 1);
      chk("ign_size", int'(out_size), 2);
      out_ready = 1'b1;
      start = 1'b1;
      start_size = 8'd4;
      tick();
      out_ready = 1'b0;
      start = 1'b0;
      chk("ign_idle_busy", int'(busy), 0);
      chk("ign_idle_valid", int'(out_valid), 0);
      chk("ign_idle_in_ready", int'(in_ready), 0);
      chk("ign_idle_size", int'(out_size), 2);
      tick();
      chk("ign_not_queued", int'(busy), 0);
      chkm("ign_matrix_kept", out_matrix, e.m);
    end

    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
